spi_baud_generator: RTL



---
 rtl/spi_baud_generator_pkg.sv | 21 ++
 rtl/spi_baud_generator_half_counter.sv | 44 ++++
 rtl/spi_baud_generator.sv | 103 ++++++++++
 3 files changed

// File: rtl/spi_baud_generator_pkg.sv
// Shared definitions for the SPI baud generator: mode encodings, divisor width
// and the divisor computation.
package spi_pkg;

    localparam int DIV_W_DEF = 12;

    typedef enum logic [1:0] {
        SPI_RUN  = 2'b00,
        SPI_WAIT = 2'b01,
        SPI_STOP = 2'b10
    } spi_mode_t;

    // Divisor = (sppr+1) << (spr+1); the shift amount is widened so spr=7 shifts by 8.
    function automatic logic [DIV_W_DEF-1:0] baud_div(input logic [2:0] sppr,
                                                      input logic [2:0] spr);
        logic [DIV_W_DEF-1:0] base;
        base = {{(DIV_W_DEF-3){1'b0}}, sppr} + {{(DIV_W_DEF-1){1'b0}}, 1'b1};
        return base << ({1'b0, spr} + 4'd1);
    endfunction

endpackage

// File: rtl/spi_baud_generator_half_counter.sv
// Half-period counter for the SPI baud generator: counts up to half-1, then wraps,
// flagging the terminal cycle (tc) and the cycle before it (tc_m1).
module spi_half_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] half,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         tc_m1
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] TWO  = {{(W-2){1'b0}}, 2'b10};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] count_r;

    // A count at or beyond half-1 (divisor shrunk mid-half) is treated as terminal.
    assign tc    = (count_r >= (half - ONE));
    assign tc_m1 = (half == ONE) ? (count_r == ZERO) : (count_r == (half - TWO));
    assign count = count_r;

    // Half-period count: cleared while idle, wraps at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO;
        end else if (clear) begin
            count_r <= ZERO;
        end else if (enable) begin
            if (tc) begin
                count_r <= ZERO;
            end else begin
                count_r <= count_r + ONE;
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/spi_baud_generator.sv
// SPI baud generator: divides PCLK into sclk and produces edge-timing strobes.
// Optional macro SPI_BAUD_SHADOW_EN: divisor settings only reload between transfers.
module spi_baud_generator
    import spi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    input  logic             cpol,
    input  logic             cphase,
    input  logic             ss,
    output logic             sclk,
    output logic             flag_low,
    output logic             flag_high,
    output logic             flags_low,
    output logic             flags_high,
    output logic [DIV_W-1:0] baudratedivisor
);

    logic             active_s;
    logic [2:0]       sel_sppr_s;
    logic [2:0]       sel_spr_s;
    logic [DIV_W-1:0] div_s;
    logic [DIV_W-1:0] half_s;
    logic [DIV_W-1:0] count_s;
    logic             tc_s;
    logic             tc_m1_s;
    logic             sclk_r;
    logic             unused_s;

    assign active_s = !ss && ((spi_mode == SPI_RUN) ||
                              ((spi_mode == SPI_WAIT) && !spiswai));

`ifdef SPI_BAUD_SHADOW_EN
    logic [2:0] sppr_r;
    logic [2:0] spr_r;

    // Shadow divisor settings, reloaded only between transfers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sppr_r <= 3'd0;
            spr_r  <= 3'd0;
        end else if (!active_s) begin
            sppr_r <= sppr;
            spr_r  <= spr;
        end else begin
            sppr_r <= sppr_r;
            spr_r  <= spr_r;
        end
    end

    assign sel_sppr_s = sppr_r;
    assign sel_spr_s  = spr_r;
`else
    assign sel_sppr_s = sppr;
    assign sel_spr_s  = spr;
`endif

    assign div_s           = DIV_W'(baud_div(sel_sppr_s, sel_spr_s));
    assign half_s          = div_s >> 1;
    assign baudratedivisor = div_s;

    spi_half_counter #(.W(DIV_W)) u_half_counter (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (!active_s),
        .enable (active_s),
        .half   (half_s),
        .count  (count_s),
        .tc     (tc_s),
        .tc_m1  (tc_m1_s)
    );

    // Serial clock: parked at cpol while idle, toggles at each terminal count.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sclk_r <= 1'b0;
        end else if (!active_s) begin
            sclk_r <= cpol;
        end else if (tc_s) begin
            sclk_r <= ~sclk_r;
        end else begin
            sclk_r <= sclk_r;
        end
    end

    assign sclk = sclk_r;

    // Strobes are gated by reset so they drop immediately when PRESETn asserts.
    assign flag_low   = PRESETn && active_s && tc_s    && !sclk_r;
    assign flag_high  = PRESETn && active_s && tc_s    &&  sclk_r;
    assign flags_low  = PRESETn && active_s && tc_m1_s && !sclk_r;
    assign flags_high = PRESETn && active_s && tc_m1_s &&  sclk_r;

    // cphase only steers strobe selection downstream; count is internal status.
    assign unused_s = ^{cphase, count_s};

endmodule
